// File: rtl/reg_file_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the multi-port register file: default geometry,
// register data/address types, the write-port count and the helper that
// resolves which write port owns a given register when both ports hit it.
// Used by: reg_file_mp, reg_file_scoreboard.
// ----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

    // Port 0 = ALU result, port 1 = load result.
    localparam int WR_PORTS = 2;

    typedef logic [DEF_DATA_W-1:0] reg_data_t;
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    // Outcome of write-port arbitration for one target register.
    typedef struct packed {
        logic hit;   // at least one port writes this target
        logic sel;   // winning port index (load port beats ALU port)
    } wr_pick_t;

    function automatic wr_pick_t wr_priority(input logic [WR_PORTS-1:0] hit);
        wr_pick_t pick;
        pick.hit = |hit;
        pick.sel = hit[1];
        return pick;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_file_scoreboard
// One pending flag per register. A flag is set when decode allocates the
// register as a destination and cleared when either writeback port writes it;
// allocation wins over a same-cycle write. Each read port looks up the flag
// of the register it addresses.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_alloc_en      allocate i_alloc_addr this cycle
//   i_alloc_addr    destination register being allocated
//   i_wr_en         per-write-port enables
//   i_wr_addr       per-write-port addresses, port j at [j*ADDR_W +: ADDR_W]
//   i_rd_addr       per-read-port addresses, port i at [i*ADDR_W +: ADDR_W]
//   o_busy          pending flag of the register addressed by each read port
// ----------------------------------------------------------------------------
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int NUM_RD   = DEF_NUM_RD,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_alloc_en,
    input  logic [ADDR_W-1:0]          i_alloc_addr,
    input  logic [WR_PORTS-1:0]        i_wr_en,
    input  logic [WR_PORTS*ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [NUM_RD-1:0]          o_busy
);

    logic [DEPTH-1:0] w_pending;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pend
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                // The hardwired zero register can never be awaited.
                assign w_pending[gi] = 1'b0;
            end else begin : g_flop
                logic r_pending;
                logic w_set;
                logic w_clr;

                assign w_set = i_alloc_en && (i_alloc_addr == ADDR_W'(gi));
                assign w_clr = (i_wr_en[0] && (i_wr_addr[0 +: ADDR_W] == ADDR_W'(gi)))
                            || (i_wr_en[1] && (i_wr_addr[ADDR_W +: ADDR_W] == ADDR_W'(gi)));

                // Set has priority: a new producer was issued while the old
                // result is retiring, so the register is still awaited.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_pending <= 1'b0;
                    end else if (w_set) begin
                        r_pending <= 1'b1;
                    end else if (w_clr) begin
                        r_pending <= 1'b0;
                    end
                end

                assign w_pending[gi] = r_pending;
            end
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_busy
            assign o_busy[gi] = w_pending[i_rd_addr[gi*ADDR_W +: ADDR_W]];
        end
    endgenerate

endmodule

// File: rtl/reg_file_mp.sv
// ----------------------------------------------------------------------------
// reg_file_mp
// Clocked multi-port register file with two prioritised write ports (ALU,
// load), NUM_RD combinational read ports, optional hardwired zero register
// and a pending scoreboard used by decode for hazard stalls.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_rd_addr       read addresses, port i at [i*ADDR_W +: ADDR_W]
//   o_rd_data       read data, port i at [i*DATA_W +: DATA_W]
//   o_rd_busy       register addressed by port i awaits a pending write
//   i_wr_en         write enables, bit 0 = ALU, bit 1 = load
//   i_wr_addr       write addresses, port j at [j*ADDR_W +: ADDR_W]
//   i_wr_data       write data, port j at [j*DATA_W +: DATA_W]
//   i_alloc_en      mark i_alloc_addr pending
//   i_alloc_addr    destination register being allocated
// Build option: define REG_FILE_MP_BYPASS_EN to forward same-cycle write data
// to matching read ports (load port first) and suppress their busy flag.
// ----------------------------------------------------------------------------
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int NUM_RD   = DEF_NUM_RD,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
    output logic [NUM_RD-1:0]          o_rd_busy,
    input  logic [WR_PORTS-1:0]        i_wr_en,
    input  logic [WR_PORTS*ADDR_W-1:0] i_wr_addr,
    input  logic [WR_PORTS*DATA_W-1:0] i_wr_data,
    input  logic                       i_alloc_en,
    input  logic [ADDR_W-1:0]          i_alloc_addr
);

    logic [DEPTH-1:0][DATA_W-1:0] w_regs;
    logic [NUM_RD-1:0]            w_sb_busy;

    reg_file_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_alloc_en   (i_alloc_en),
        .i_alloc_addr (i_alloc_addr),
        .i_wr_en      (i_wr_en),
        .i_wr_addr    (i_wr_addr),
        .i_rd_addr    (i_rd_addr),
        .o_busy       (w_sb_busy)
    );

    genvar gi;
    generate
        // Storage: one register per entry, written by the winning port.
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_flop
                logic [DATA_W-1:0]   r_q;
                logic [WR_PORTS-1:0] w_hit;
                wr_pick_t            w_pick;

                assign w_hit[0] = i_wr_en[0] && (i_wr_addr[0 +: ADDR_W] == ADDR_W'(gi));
                assign w_hit[1] = i_wr_en[1] && (i_wr_addr[ADDR_W +: ADDR_W] == ADDR_W'(gi));
                assign w_pick   = wr_priority(w_hit);

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (w_pick.hit) begin
                        r_q <= w_pick.sel ? i_wr_data[DATA_W +: DATA_W]
                                          : i_wr_data[0 +: DATA_W];
                    end
                end

                assign w_regs[gi] = r_q;
            end
        end

        // Read ports.
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_arr;

            assign w_ra  = i_rd_addr[gi*ADDR_W +: ADDR_W];
            assign w_arr = w_regs[w_ra];
`ifdef REG_FILE_MP_BYPASS_EN
            logic [WR_PORTS-1:0] w_hit;
            wr_pick_t            w_pick;
            logic                w_fwd;

            assign w_hit[0] = i_wr_en[0] && (i_wr_addr[0 +: ADDR_W] == w_ra);
            assign w_hit[1] = i_wr_en[1] && (i_wr_addr[ADDR_W +: ADDR_W] == w_ra);
            assign w_pick   = wr_priority(w_hit);
            // No forwarding while reset is held (outputs must read zero) or
            // for the hardwired zero register.
            assign w_fwd    = rst_n && w_pick.hit && !((ZERO_REG != 0) && (w_ra == '0));

            assign o_rd_data[gi*DATA_W +: DATA_W] =
                !w_fwd      ? w_arr :
                w_pick.sel  ? i_wr_data[DATA_W +: DATA_W] : i_wr_data[0 +: DATA_W];
            assign o_rd_busy[gi] = w_sb_busy[gi] && !w_fwd;
`else
            assign o_rd_data[gi*DATA_W +: DATA_W] = w_arr;
            assign o_rd_busy[gi] = w_sb_busy[gi];
`endif
        end
    endgenerate

endmodule
